bist_harness_ctrl: RTL and testbench
====================================

Name: bist_harness_ctrl

Overview:
Parametrised second-generation built-in self-test harness that wraps an arbitrary pipelined datapath DUT. It has:
- an internal Galois LFSR stimulus driver, with an external pass-through alternative;
- a MISR or direct-capture response monitor;
- a run FSM with a programmable vector count;
- an outstanding-response drain with timeout;
- an on-chip golden-signature compare producing a pass/fail result.

The DUT sits outside the block, on the o_dut_* / i_dut_* ports. The block sits between chip-level test pins and the DUT.

Parameters:
IN_W, 49, stimulus vector width
OUT_W, 54, response/signature width
CNT_W, 16, vector and response counter width
DRAIN_W, 8, drain timeout counter width
IN_POLY, 49'h0000000000201, Galois feedback taps for the LFSR (x^49+x^9+1)
OUT_POLY, 54'h00003000040001, Galois feedback taps for the MISR

Ports:
i_clk  in  1  clock
i_async_rst_n  in  1  asynchronous active-low reset; internally synchronised (assert async, deassert after 2 i_clk edges)
i_en  in  1  synchronous enable; when 0 every register holds and o_dut_vld=0
i_start  in  1  pulse; starts a run from IDLE or DONE
i_mode  in  2  [1]=driver: 0 external, 1 LFSR; [0]=monitor: 0 direct capture, 1 MISR; sampled at start
i_num_vec  in  CNT_W  number of vectors to issue; latched at start
i_drain_max  in  DRAIN_W  drain timeout in cycles; latched at start
i_seed_in  in  IN_W  LFSR seed; an all-zero value is replaced by 1
i_seed_sig  in  OUT_W  MISR initial value
i_golden  in  OUT_W  expected signature
i_ext_vld  in  1  external stimulus valid (external driver mode)
i_ext_data  in  IN_W  external stimulus
o_dut_vld  out  1  registered stimulus valid to the DUT
o_dut_data  out  IN_W  registered stimulus to the DUT
i_dut_vld  in  1  DUT response valid
i_dut_data  in  OUT_W  DUT response
o_busy  out  1  high in LOAD, RUN and DRAIN
o_done  out  1  high in DONE
o_pass  out  1  result; valid while o_done=1
o_timeout  out  1  drain timed out; sticky until next start
o_signature  out  OUT_W  current MISR / captured value
o_vec_cnt  out  CNT_W  vectors issued this run
o_rsp_cnt  out  CNT_W  responses accepted this run

Behaviour:
- Reset state:
  - FSM=IDLE; all outputs 0; LFSR=1; MISR=0.
  - Asserting reset mid-run aborts immediately; no partial result is kept.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
  - IDLE --i_start--> LOAD.
  - LOAD (1 cycle):
    - LFSR <= seed (zero forced to 1); MISR <= i_seed_sig.
    - Counters cleared; o_timeout cleared.
    - Mode, num_vec and drain_max latched.
    - Next state is RUN, or DRAIN if num_vec=0.
  - RUN:
    - LFSR mode: o_dut_vld=1 every enabled cycle; o_dut_data=current LFSR; LFSR advances after each issue.
    - External mode: o_dut_vld/o_dut_data = i_ext_vld/i_ext_data, registered with 1 cycle latency; only counted while vec_cnt<num_vec.
    - Move to DRAIN in the cycle the num_vec-th vector is issued.
  - DRAIN:
    - The drain counter increments each enabled cycle.
    - Go to DONE when rsp_cnt==num_vec, or when the drain counter reaches drain_max (set o_timeout).
    - If both conditions hold in the same cycle, completion wins: no timeout.
  - DONE: holds until i_start, which goes to LOAD (restart with no pass through IDLE). i_start in any other non-IDLE state is ignored.
- LFSR step (Galois): next = {s[IN_W-2:0],1'b0} ^ (s[IN_W-1] ? IN_POLY : 0).
- Response handling:
  - Responses are accepted only in RUN and DRAIN, and only while rsp_cnt<num_vec.
  - Extra responses and responses in IDLE, LOAD or DONE are ignored and not counted.
  - MISR mode: sig <= galois_step(sig, OUT_POLY) ^ i_dut_data.
  - Direct mode: sig <= i_dut_data (last response).
- Pass result: o_pass = (o_signature==i_golden) && !o_timeout, evaluated on entry to DONE and registered. i_golden must be stable from DRAIN onward.
- Counters saturate at all-ones; no wrap.
- With i_en=0, a response arriving on i_dut_vld is dropped; the DUT shares the same gated enable.

Test Plan:
- LFSR mode, seed=1, num_vec=3, DUT = 1-cycle zero-extending loopback, MISR mode, seed_sig=0 -> o_dut_data 1,2,4 on consecutive cycles. Signature 0x1, 0x0, 0x4. i_golden=4 gives o_done=1, o_pass=1, o_vec_cnt=o_rsp_cnt=3.
- Same run with direct monitor mode and golden=4 -> o_signature=4, pass=1. Golden=5 -> pass=0, o_timeout=0.
- DUT returns nothing, drain_max=8 -> DONE reached 8 cycles after DRAIN entry; o_timeout=1, pass=0, o_rsp_cnt=0.
- num_vec=0, seed_sig=golden=0x2A -> LOAD, DRAIN, DONE with no o_dut_vld pulse; pass=1.
- seed_in=0, num_vec=2 -> vectors 1,2. External mode with i_ext_vld toggling every other cycle, num_vec=4 -> exactly 4 o_dut_vld pulses, each 1 cycle after its input.
- Reset asserted mid-RUN, then i_en=0 for 5 cycles in a later run -> all outputs 0 and FSM in IDLE within 0 cycles of assert. During the i_en=0 cycles, counters and LFSR are frozen, o_dut_vld=0, and the vector sequence resumes unchanged.

Source files
------------

// File: rtl/bist_harness_ctrl.sv
// rtl/bist_harness_ctrl.sv - BIST harness: LFSR/external stimulus, MISR/direct capture, run FSM with drain timeout
// Sits between chip test pins and an external pipelined DUT on the o_dut_*/i_dut_* ports.
module bist_harness_ctrl #(
  parameter int              IN_W     = 49,
  parameter int              OUT_W    = 54,
  parameter int              CNT_W    = 16,
  parameter int              DRAIN_W  = 8,
  parameter logic [IN_W-1:0]  IN_POLY  = 49'h0000000000201,
  parameter logic [OUT_W-1:0] OUT_POLY = 54'h00003000040001
) (
  input  logic               i_clk,
  input  logic               i_async_rst_n,
  input  logic               i_en,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [CNT_W-1:0]   i_num_vec,
  input  logic [DRAIN_W-1:0] i_drain_max,
  input  logic [IN_W-1:0]    i_seed_in,
  input  logic [OUT_W-1:0]   i_seed_sig,
  input  logic [OUT_W-1:0]   i_golden,
  input  logic               i_ext_vld,
  input  logic [IN_W-1:0]    i_ext_data,
  output logic               o_dut_vld,
  output logic [IN_W-1:0]    o_dut_data,
  input  logic               i_dut_vld,
  input  logic [OUT_W-1:0]   i_dut_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [OUT_W-1:0]   o_signature,
  output logic [CNT_W-1:0]   o_vec_cnt,
  output logic [CNT_W-1:0]   o_rsp_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] s);
    return {s[IN_W-2:0], 1'b0} ^ (s[IN_W-1] ? IN_POLY : '0);
  endfunction

  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s);
    return {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? OUT_POLY : '0);
  endfunction

  // Reset asserts asynchronously and releases two clock edges later.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IN_W-1:0]    r_lfsr;
  logic [OUT_W-1:0]   r_sig;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_num_vec;
  logic [DRAIN_W-1:0] r_drain_max;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [CNT_W-1:0]   r_rsp_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_timeout;
  logic               r_pass;
  logic               r_dut_vld;
  logic [IN_W-1:0]    r_dut_data;

  logic               w_issue;
  logic               w_last_issue;
  logic               w_rsp_ok;
  logic               w_complete;
  logic               w_drain_hit;
  logic               w_timeout_set;
  logic [OUT_W-1:0]   w_sig_nxt;
  logic [IN_W-1:0]    w_seed;

  assign w_issue      = i_en && (r_state == S_RUN) && (r_mode[1] || i_ext_vld) &&
                        (r_vec_cnt < r_num_vec);
  assign w_last_issue = w_issue && ((r_vec_cnt + CNT_W'(1)) == r_num_vec);
  assign w_rsp_ok     = i_en && i_dut_vld && ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                        (r_rsp_cnt < r_num_vec);
  assign w_complete   = (r_rsp_cnt == r_num_vec);
  assign w_drain_hit  = (({1'b0, r_drain_cnt} + (DRAIN_W+1)'(1)) >= {1'b0, r_drain_max});
  assign w_sig_nxt    = !w_rsp_ok ? r_sig :
                        (r_mode[0] ? (misr_step(r_sig) ^ i_dut_data) : i_dut_data);
  assign w_seed       = (i_seed_in == '0) ? IN_W'(1) : i_seed_in;

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_set = 1'b0;
    if (i_en) begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
        S_LOAD:  w_state_nxt = (i_num_vec == '0) ? S_DRAIN : S_RUN;
        S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
        S_DRAIN: begin
          // A completed run takes priority over a timeout in the same cycle.
          if (w_complete) begin
            w_state_nxt = S_DONE;
          end else if (w_drain_hit) begin
            w_state_nxt   = S_DONE;
            w_timeout_set = 1'b1;
          end
        end
        S_DONE:  if (i_start) w_state_nxt = S_LOAD;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lfsr      <= IN_W'(1);
      r_sig       <= '0;
      r_mode      <= '0;
      r_num_vec   <= '0;
      r_drain_max <= '0;
      r_vec_cnt   <= '0;
      r_rsp_cnt   <= '0;
      r_drain_cnt <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
      r_dut_vld   <= 1'b0;
      r_dut_data  <= '0;
    end else if (i_en) begin
      r_dut_vld <= w_issue;
      if (w_issue) r_dut_data <= r_mode[1] ? r_lfsr : i_ext_data;
      if (r_state == S_LOAD) begin
        r_lfsr      <= w_seed;
        r_sig       <= i_seed_sig;
        r_mode      <= i_mode;
        r_num_vec   <= i_num_vec;
        r_drain_max <= i_drain_max;
        r_vec_cnt   <= '0;
        r_rsp_cnt   <= '0;
        r_drain_cnt <= '0;
        r_timeout   <= 1'b0;
        r_pass      <= 1'b0;
      end else begin
        if (w_issue) begin
          if (r_mode[1]) r_lfsr <= lfsr_step(r_lfsr);
          if (r_vec_cnt != '1) r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        end
        if (w_rsp_ok) begin
          r_sig <= w_sig_nxt;
          if (r_rsp_cnt != '1) r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
        end
        if ((r_state == S_DRAIN) && (r_drain_cnt != '1))
          r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
          r_timeout <= w_timeout_set;
          r_pass    <= (w_sig_nxt == i_golden) && !w_timeout_set;
        end
      end
    end
  end

  assign o_dut_vld   = r_dut_vld & i_en;
  assign o_dut_data  = r_dut_data;
  assign o_busy      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_signature = r_sig;
  assign o_vec_cnt   = r_vec_cnt;
  assign o_rsp_cnt   = r_rsp_cnt;

endmodule

// File: tb/tb_bist_harness_ctrl.sv
// tb/tb_bist_harness_ctrl.sv - directed bench for bist_harness_ctrl with a 1-cycle loopback DUT
module tb_bist_harness_ctrl;
  localparam int IN_W    = 49;
  localparam int OUT_W   = 54;
  localparam int CNT_W   = 16;
  localparam int DRAIN_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         mode = '0;
  logic [CNT_W-1:0]   num_vec = '0;
  logic [DRAIN_W-1:0] drain_max = '0;
  logic [IN_W-1:0]    seed_in = '0;
  logic [OUT_W-1:0]   seed_sig = '0;
  logic [OUT_W-1:0]   golden = '0;
  logic               ext_vld = 1'b0;
  logic [IN_W-1:0]    ext_data = '0;
  logic               dut_vld_o;
  logic [IN_W-1:0]    dut_data_o;
  logic               dut_vld_i = 1'b0;
  logic [OUT_W-1:0]   dut_data_i = '0;
  logic               busy, done, pass, timeout;
  logic [OUT_W-1:0]   signature;
  logic [CNT_W-1:0]   vec_cnt, rsp_cnt;

  int checks = 0;
  int errors = 0;
  logic mute = 1'b0;
  logic [IN_W-1:0]  q_vec[$];
  logic [OUT_W-1:0] q_sig[$];
  logic [CNT_W-1:0] prev_rsp = '0;

  bist_harness_ctrl dut (
    .i_clk(clk), .i_async_rst_n(rst_n), .i_en(en), .i_start(start), .i_mode(mode),
    .i_num_vec(num_vec), .i_drain_max(drain_max), .i_seed_in(seed_in), .i_seed_sig(seed_sig),
    .i_golden(golden), .i_ext_vld(ext_vld), .i_ext_data(ext_data),
    .o_dut_vld(dut_vld_o), .o_dut_data(dut_data_o), .i_dut_vld(dut_vld_i), .i_dut_data(dut_data_i),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout), .o_signature(signature),
    .o_vec_cnt(vec_cnt), .o_rsp_cnt(rsp_cnt)
  );

  always #5 clk = ~clk;

  // Loopback DUT: zero-extends the stimulus, one cycle latency, shares the enable.
  always @(posedge clk) begin
    if (en) begin
      dut_vld_i  <= dut_vld_o & ~mute;
      dut_data_i <= {{(OUT_W-IN_W){1'b0}}, dut_data_o};
    end
  end

  always @(negedge clk) begin
    if (dut_vld_o) q_vec.push_back(dut_data_o);
    if (rsp_cnt > prev_rsp) q_sig.push_back(signature);
    prev_rsp = rsp_cnt;
  end

  task automatic start_run(input logic [1:0] m, input logic [CNT_W-1:0] nv,
                           input logic [DRAIN_W-1:0] dm, input logic [IN_W-1:0] si,
                           input logic [OUT_W-1:0] ss, input logic [OUT_W-1:0] g);
    mode = m; num_vec = nv; drain_max = dm; seed_in = si; seed_sig = ss; golden = g;
    q_vec.delete(); q_sig.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: o_done=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %b expected 0", pass); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    checks++; if (signature !== '0) begin errors++; $display("FAIL rst_sig: got %0h expected 0", signature); end
    checks++; if (vec_cnt !== '0) begin errors++; $display("FAIL rst_vec: got %0d expected 0", vec_cnt); end
    checks++; if (rsp_cnt !== '0) begin errors++; $display("FAIL rst_rsp: got %0d expected 0", rsp_cnt); end
    checks++; if (dut_vld_o !== 1'b0) begin errors++; $display("FAIL rst_dut_vld: got %b expected 0", dut_vld_o); end
    checks++; if (dut_data_o !== '0) begin errors++; $display("FAIL rst_dut_data: got %0h expected 0", dut_data_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_lfsr_misr();
    logic [IN_W-1:0]  ev[3] = '{49'd1, 49'd2, 49'd4};
    logic [OUT_W-1:0] es[3] = '{54'h1, 54'h0, 54'h4};
    start_run(2'b11, 16'd3, 8'd8, 49'd1, 54'd0, 54'd4);
    wait_done();
    checks++; if (q_vec.size() !== 3) begin errors++; $display("FAIL lm_nvec: got %0d expected 3", q_vec.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (q_vec[i] !== ev[i]) begin errors++; $display("FAIL lm_vec%0d: got %0h expected %0h", i, q_vec[i], ev[i]); end
      checks++; if (q_sig[i] !== es[i]) begin errors++; $display("FAIL lm_sig%0d: got %0h expected %0h", i, q_sig[i], es[i]); end
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL lm_pass: got %b expected 1", pass); end
    checks++; if (vec_cnt !== 16'd3 || rsp_cnt !== 16'd3) begin errors++; $display("FAIL lm_cnts: got %0d/%0d expected 3/3", vec_cnt, rsp_cnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL lm_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_direct();
    start_run(2'b10, 16'd3, 8'd8, 49'd1, 54'd0, 54'd4);
    wait_done();
    checks++; if (signature !== 54'd4) begin errors++; $display("FAIL dir_sig: got %0h expected 4", signature); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL dir_pass: got %b expected 1", pass); end
    start_run(2'b10, 16'd3, 8'd8, 49'd1, 54'd0, 54'd5);
    wait_done();
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL dir_badgold_pass: got %b expected 0", pass); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL dir_badgold_to: got %b expected 0", timeout); end
  endtask

  task automatic test_timeout();
    int n = 0;
    mute = 1'b1;
    start_run(2'b11, 16'd3, 8'd8, 49'd1, 54'd0, 54'd4);
    @(negedge clk);
    while (vec_cnt !== 16'd3 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL to_cycles: got %0d expected 8", n); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_pass: got %b expected 0", pass); end
    checks++; if (rsp_cnt !== '0) begin errors++; $display("FAIL to_rsp: got %0d expected 0", rsp_cnt); end
    mute = 1'b0;
  endtask

  task automatic test_zero_vec();
    start_run(2'b11, 16'd0, 8'd8, 49'd1, 54'h2A, 54'h2A);
    wait_done();
    checks++; if (q_vec.size() !== 0) begin errors++; $display("FAIL zv_pulses: got %0d expected 0", q_vec.size()); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zv_pass: got %b expected 1", pass); end
    checks++; if (signature !== 54'h2A) begin errors++; $display("FAIL zv_sig: got %0h expected 2a", signature); end
  endtask

  task automatic test_seed_zero();
    start_run(2'b11, 16'd2, 8'd8, 49'd0, 54'd0, 54'd0);
    wait_done();
    checks++; if (q_vec.size() !== 2) begin errors++; $display("FAIL sz_nvec: got %0d expected 2", q_vec.size()); end
    checks++; if (q_vec[0] !== 49'd1 || q_vec[1] !== 49'd2) begin errors++; $display("FAIL sz_vecs: got %0h,%0h expected 1,2", q_vec[0], q_vec[1]); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL sz_pass: got %b expected 1", pass); end
  endtask

  task automatic test_external();
    int issued = 0;
    logic exp_vld;
    start_run(2'b01, 16'd4, 8'd8, 49'd1, 54'd0, 54'd514);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      ext_vld  = (k % 2 == 0);
      ext_data = IN_W'(100 + k);
      @(negedge clk);
      exp_vld = (k % 2 == 0) && (issued < 4);
      checks++; if (dut_vld_o !== exp_vld) begin errors++; $display("FAIL ext_vld k%0d: got %b expected %b", k, dut_vld_o, exp_vld); end
      if (exp_vld) begin
        issued++;
        checks++; if (dut_data_o !== IN_W'(100 + k)) begin errors++; $display("FAIL ext_data k%0d: got %0d expected %0d", k, dut_data_o, 100 + k); end
      end
    end
    ext_vld = 1'b0;
    wait_done();
    checks++; if (q_vec.size() !== 4) begin errors++; $display("FAIL ext_pulses: got %0d expected 4", q_vec.size()); end
    checks++; if (signature !== 54'd514) begin errors++; $display("FAIL ext_sig: got %0d expected 514", signature); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ext_pass: got %b expected 1", pass); end
  endtask

  task automatic test_reset_midrun();
    start_run(2'b11, 16'd10, 8'd8, 49'd1, 54'd0, 54'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mr_state: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (vec_cnt !== '0 || rsp_cnt !== '0) begin errors++; $display("FAIL mr_cnts: got %0d/%0d expected 0/0", vec_cnt, rsp_cnt); end
    checks++; if (dut_vld_o !== 1'b0 || dut_data_o !== '0) begin errors++; $display("FAIL mr_dut: got %b/%0h expected 0/0", dut_vld_o, dut_data_o); end
    checks++; if (signature !== '0 || pass !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL mr_result: got sig=%0h pass=%b to=%b expected 0", signature, pass, timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable_freeze();
    logic [IN_W-1:0] ev[6] = '{49'd1, 49'd2, 49'd4, 49'd8, 49'd16, 49'd32};
    logic [CNT_W-1:0] v, r;
    int n = 0;
    start_run(2'b11, 16'd6, 8'd16, 49'd1, 54'd0, 54'd0);
    @(negedge clk);
    while (vec_cnt !== 16'd2 && n < 50) begin @(negedge clk); n++; end
    #1 en = 1'b0;
    v = vec_cnt;
    r = rsp_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (dut_vld_o !== 1'b0) begin errors++; $display("FAIL fr_vld c%0d: got %b expected 0", i, dut_vld_o); end
      checks++; if (vec_cnt !== v || rsp_cnt !== r) begin errors++; $display("FAIL fr_cnts c%0d: got %0d/%0d expected %0d/%0d", i, vec_cnt, rsp_cnt, v, r); end
    end
    #1 en = 1'b1;
    wait_done();
    checks++; if (q_vec.size() !== 6) begin errors++; $display("FAIL fr_nvec: got %0d expected 6", q_vec.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (q_vec[i] !== ev[i]) begin errors++; $display("FAIL fr_vec%0d: got %0h expected %0h", i, q_vec[i], ev[i]); end
    end
    checks++; if (rsp_cnt !== 16'd6 || pass !== 1'b1) begin errors++; $display("FAIL fr_result: got rsp=%0d pass=%b expected 6 1", rsp_cnt, pass); end
  endtask

  initial begin
    test_reset();
    test_lfsr_misr();
    test_direct();
    test_timeout();
    test_zero_vec();
    test_seed_zero();
    test_external();
    test_reset_midrun();
    test_enable_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
